ram_port_arbiter: RTL and testbench

//  Shares one single-port-per-direction Ram instance between two requesters (port 0, port 1).

---
 rtl/ram_port_arbiter_pkg.sv | 19 +
 rtl/rr_burst_picker.sv | 74 +++++++
 rtl/ram_port_arbiter.sv | 90 +++++++++
 tb/tb_ram_port_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and helpers for the two-port Ram arbiter.
// No logic. Latency: n/a.
// Backpressure: n/a.
package ram_port_arbiter_pkg;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // One-hot per-port vector for a port index
    function automatic logic [1:0] port_onehot(input logic p);
        return (p == PORT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

`ifndef RPA_SLICE
// Port-p field of a packed two-port bus whose fields are w bits wide
`define RPA_SLICE(bus, p, w) bus[(p)*(w) +: (w)]
`endif

// File: rtl/rr_burst_picker.sv
// Two-way round-robin winner select with a burst limit, plus lastGrant/run state.
// Latency: grant is combinational from req and state; state updates at posedge.
// Backpressure: none; a requester that is not granted simply holds its request.
module rr_burst_picker
    import ram_port_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       res,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       grant_vld_o,
    output logic       grant_port_o
);

    localparam int              RUN_W   = $clog2(MAX_BURST + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_BURST);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic             last_grant_q, last_grant_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             win_vld;
    logic             win_port;

    // Pick the winner: a lone requester always wins; under contention the
    // previous owner keeps the Ram until it has used up its burst allowance.
    always_comb begin
        win_vld  = 1'b0;
        win_port = PORT0;
        if (!res) begin
            if (req_i[0] && req_i[1]) begin
                win_vld  = 1'b1;
                win_port = (run_q < RUN_MAX) ? last_grant_q : ~last_grant_q;
            end else if (req_i[0]) begin
                win_vld  = 1'b1;
                win_port = PORT0;
            end else if (req_i[1]) begin
                win_vld  = 1'b1;
                win_port = PORT1;
            end
        end
    end

    // Next burst state: extend the run on a repeat grant, restart it on a switch
    always_comb begin
        last_grant_d = last_grant_q;
        run_d        = run_q;
        if (win_vld) begin
            if (win_port == last_grant_q) begin
                run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
            end else begin
                last_grant_d = win_port;
                run_d        = RUN_ONE;
            end
        end
    end

    // Reset to "port 1 has exhausted its burst" so port 0 wins the first contention
    always_ff @(posedge clk) begin
        if (res) begin
            last_grant_q <= PORT1;
            run_q        <= RUN_MAX;
        end else begin
            last_grant_q <= last_grant_d;
            run_q        <= run_d;
        end
    end

    assign gnt_o        = win_vld ? port_onehot(win_port) : 2'b00;
    assign grant_vld_o  = win_vld;
    assign grant_port_o = win_port;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one Ram between two requesters: strobe mux plus tagged read-response pipeline.
// Latency: grant combinational; read data returns one cycle after the read grant.
// Backpressure: req/gnt on the request side; responses cannot be stalled.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 4
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [1:0]              req,
    input  logic [1:0]              reqWe,
    input  logic [2*ADDR_WIDTH-1:0] reqAddr,
    input  logic [2*WIDTH-1:0]      reqData,
    output logic [1:0]              gnt,
    output logic [1:0]              rvalid,
    output logic [WIDTH-1:0]        rdata,
    output logic                    ramRe,
    output logic                    ramWe,
    output logic [ADDR_WIDTH-1:0]   ramReadAddr,
    output logic [ADDR_WIDTH-1:0]   ramWriteAddr,
    output logic [WIDTH-1:0]        ramDataIn,
    input  logic [WIDTH-1:0]        ramDataOut
);

    logic                  grant_vld;
    logic                  grant_port;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_data;
    logic                  rd_grant;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_owner_q, rd_owner_d;

    rr_burst_picker #(
        .MAX_BURST (MAX_BURST)
    ) u_picker (
        .clk          (clk),
        .res          (res),
        .req_i        (req),
        .gnt_o        (gnt),
        .grant_vld_o  (grant_vld),
        .grant_port_o (grant_port)
    );

    assign sel_we   = reqWe[grant_port];
    assign sel_addr = `RPA_SLICE(reqAddr, grant_port, ADDR_WIDTH);
    assign sel_data = `RPA_SLICE(reqData, grant_port, WIDTH);
    assign rd_grant = grant_vld & ~sel_we;

    // Drive the Ram from the granted port; idle strobes and zeroed buses otherwise
    always_comb begin
        ramRe        = 1'b0;
        ramWe        = 1'b0;
        ramReadAddr  = '0;
        ramWriteAddr = '0;
        ramDataIn    = '0;
        if (grant_vld) begin
            ramWe        = sel_we;
            ramRe        = ~sel_we;
            ramReadAddr  = sel_addr;
            ramWriteAddr = sel_addr;
            ramDataIn    = sel_data;
        end
    end

    // Remember who owns the read currently in flight inside the Ram
    always_comb begin
        rd_pend_d  = rd_grant;
        rd_owner_d = rd_grant ? grant_port : rd_owner_q;
    end

    // Read-response pipeline state
    always_ff @(posedge clk) begin
        if (res) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= PORT0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Masking with res drops a read that was granted just before reset rose
    assign rvalid = (rd_pend_q && !res) ? port_onehot(rd_owner_q) : 2'b00;
    assign rdata  = ramDataOut;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            res;
    logic            init_mem;
    logic [1:0]      req;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input logic [9:0] a);
        return 32'hC0DE_0000 | {22'h0, a};
    endfunction

    // Two DUTs on the same stimulus: instance 0 MAX_BURST=4, instance 1 MAX_BURST=1,
    // each with its own Ram model (latched read address, write beats read).
    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [1:0]    gnt, rvalid;
        logic [DW-1:0] rdata, ram_din, ram_dout;
        logic          ram_re, ram_we;
        logic [AW-1:0] ram_ra, ram_wa;
        logic [DW-1:0] mem [1024];
        logic [AW-1:0] raddr_q;

        ram_port_arbiter #(
            .WIDTH      (DW),
            .ADDR_WIDTH (AW),
            .MAX_BURST  ((k == 0) ? 4 : 1)
        ) u_dut (
            .clk          (clk),
            .res          (res),
            .req          (req),
            .reqWe        (req_we),
            .reqAddr      (req_addr),
            .reqData      (req_data),
            .gnt          (gnt),
            .rvalid       (rvalid),
            .rdata        (rdata),
            .ramRe        (ram_re),
            .ramWe        (ram_we),
            .ramReadAddr  (ram_ra),
            .ramWriteAddr (ram_wa),
            .ramDataIn    (ram_din),
            .ramDataOut   (ram_dout)
        );

        always @(posedge clk) begin
            if (init_mem) begin
                for (int i = 0; i < 1024; i++) mem[i] <= pattern(10'(i));
                raddr_q <= '0;
            end else if (ram_we) begin
                mem[ram_wa] <= ram_din;
            end else if (ram_re) begin
                raddr_q <= ram_ra;
            end
        end

        assign ram_dout = mem[raddr_q];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_ports(input logic [1:0] r, input logic [1:0] we,
                             input logic [9:0] a0, input logic [9:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1);
        req      = r;
        req_we   = we;
        req_addr = {a1, a0};
        req_data = {d1, d0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        res = 1'b1;
        req = 2'b00;
        next_cycle();
        res = 1'b0;
    endtask

    logic [1:0] exp0, exp1, prev0, prev1;

    initial begin
        // ---- reset state (contended request held while res=1) ----
        res      = 1'b1;
        init_mem = 1'b1;
        set_ports(2'b11, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("rst_gnt",    {g_dut[1].gnt, g_dut[0].gnt}, 4'b0000);
        check("rst_rvalid", {g_dut[1].rvalid, g_dut[0].rvalid}, 4'b0000);
        check("rst_strobe", {g_dut[0].ram_re, g_dut[0].ram_we}, 2'b00);

        // ---- 1: write 0xDEADBEEF to 0x010, read it back ----
        next_cycle();
        init_mem = 1'b0;
        res      = 1'b0;
        set_ports(2'b01, 2'b01, 10'h010, 10'h0, 32'hDEAD_BEEF, 32'h0);
        @(negedge clk);
        check("t1_wr_gnt",    g_dut[0].gnt, 2'b01);
        check("t1_wr_strobe", {g_dut[0].ram_re, g_dut[0].ram_we}, 2'b01);
        check("t1_wr_addr",   g_dut[0].ram_wa, 10'h010);
        next_cycle();
        set_ports(2'b01, 2'b00, 10'h010, 10'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("t1_rd_gnt",    g_dut[0].gnt, 2'b01);
        check("t1_rd_strobe", {g_dut[0].ram_re, g_dut[0].ram_we}, 2'b10);
        check("t1_rd_rvalid", g_dut[0].rvalid, 2'b00);
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        check("t1_rvalid", g_dut[0].rvalid, 2'b01);
        check("t1_rdata",  g_dut[0].rdata, 32'hDEAD_BEEF);
        check("t1_idle",   g_dut[0].gnt, 2'b00);
        next_cycle();

        // ---- 2 & 3: both ports read continuously from reset ----
        pulse_reset();
        set_ports(2'b11, 2'b00, 10'h020, 10'h021, 32'h0, 32'h0);
        prev0 = 2'b00;
        prev1 = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp0 = (((i / 4) % 2) == 1) ? 2'b10 : 2'b01;
            exp1 = ((i % 2) == 1) ? 2'b10 : 2'b01;
            check($sformatf("t2_gnt[%0d]", i),    g_dut[0].gnt, exp0);
            check($sformatf("t3_gnt[%0d]", i),    g_dut[1].gnt, exp1);
            check($sformatf("t2_rvalid[%0d]", i), g_dut[0].rvalid, prev0);
            check($sformatf("t3_rvalid[%0d]", i), g_dut[1].rvalid, prev1);
            if (prev0 != 2'b00)
                check($sformatf("t2_rdata[%0d]", i), g_dut[0].rdata,
                      pattern((prev0 == 2'b01) ? 10'h020 : 10'h021));
            if (prev1 != 2'b00)
                check($sformatf("t3_rdata[%0d]", i), g_dut[1].rdata,
                      pattern((prev1 == 2'b01) ? 10'h020 : 10'h021));
            check($sformatf("t3_re_we[%0d]", i),
                  {g_dut[1].ram_re & g_dut[1].ram_we, g_dut[0].ram_re & g_dut[0].ram_we}, 2'b00);
            prev0 = exp0;
            prev1 = exp1;
            next_cycle();
        end
        req = 2'b00;
        next_cycle();

        // ---- 4: port 1 alone reads 0x3FF then 0x000 back-to-back ----
        pulse_reset();
        set_ports(2'b10, 2'b00, 10'h0, 10'h3FF, 32'h0, 32'h0);
        @(negedge clk);
        check("t4_gnt0",    g_dut[0].gnt, 2'b10);
        check("t4_rvalid0", g_dut[0].rvalid, 2'b00);
        next_cycle();
        set_ports(2'b10, 2'b00, 10'h0, 10'h000, 32'h0, 32'h0);
        @(negedge clk);
        check("t4_gnt1",    g_dut[0].gnt, 2'b10);
        check("t4_rvalid1", g_dut[0].rvalid, 2'b10);
        check("t4_rdata1",  g_dut[0].rdata, pattern(10'h3FF));
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        check("t4_rvalid2", g_dut[0].rvalid, 2'b10);
        check("t4_rdata2",  g_dut[0].rdata, pattern(10'h000));
        next_cycle();
        @(negedge clk);
        check("t4_rvalid3", g_dut[0].rvalid, 2'b00);
        next_cycle();

        // ---- 5: read grant to port 1, then reset the next cycle ----
        pulse_reset();
        set_ports(2'b10, 2'b00, 10'h0, 10'h005, 32'h0, 32'h0);
        @(negedge clk);
        check("t5_gnt", g_dut[0].gnt, 2'b10);
        next_cycle();
        res = 1'b1;
        @(negedge clk);
        check("t5_rvalid_rst", g_dut[0].rvalid, 2'b00);
        check("t5_gnt_rst",    g_dut[0].gnt, 2'b00);
        next_cycle();
        res = 1'b0;
        req = 2'b00;
        @(negedge clk);
        check("t5_rvalid_post", g_dut[0].rvalid, 2'b00);
        next_cycle();
        req = 2'b11;
        @(negedge clk);
        check("t5_first_contend", g_dut[0].gnt, 2'b01);
        next_cycle();
        req = 2'b00;
        next_cycle();

        // ---- 6: idle gap keeps lastGrant/run ----
        pulse_reset();
        set_ports(2'b01, 2'b00, 10'h001, 10'h002, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("t6_solo[%0d]", i), g_dut[0].gnt, 2'b01);
            next_cycle();
        end
        req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t6_idle[%0d]", i), g_dut[0].gnt, 2'b00);
            next_cycle();
        end
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t6_both[%0d]", i), g_dut[0].gnt, (i == 2) ? 2'b10 : 2'b01);
            next_cycle();
        end
        req = 2'b00;
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
